video_pattern_gen: RTL
======================

# video_pattern_gen

Parametrised video timing and test-pattern generator for the latency-measurement path. Produces hsync/vsync/DE and a 24-bit pixel stream from a `VideoMode` descriptor, with N blinking white field boxes on a configurable frame period. Mode changes are shadowed and only take effect at a frame boundary. A frame-start strobe and a box-visibility flag are aligned to the output pixels for the sensor and measurement logic downstream.

## Interface
Parameters:
- `CNT_WIDTH`, 12: width of the X/Y counters and all mode timing fields.
- `NUM_FIELDS`, 3: number of field boxes, 1..8.
- `BLINK_FRAMES`, 6: frames per blink half-period. 0 means the boxes are always shown.
- `OUT_DELAY`, 2: extra pipeline stages on every output, 0..8.

Ports:
- `clock`  in  1: pixel clock.
- `reset`  in  1: synchronous, active-high.
- `videoMode`  in  VideoMode: h/v sync, back porch, active, total, sync polarities, `h_field_start`, `h_field_end`.
- `v_field_bounds`  in  NUM_FIELDS*2*CNT_WIDTH: per field i, `{end, start}` packed at bits [i*2*CNT_WIDTH +: 2*CNT_WIDTH].
- `red`, `green`, `blue`  out  8 each: pixel data.
- `de`  out  1: data enable.
- `hsync`, `vsync`  out  1 each: syncs at the mode polarity.
- `frame_start`  out  1: one-cycle pulse aligned with the output of counter position (0,0).
- `fields_visible`  out  1: current blink phase, aligned with the pixel outputs.

## Operation
- **Shadow mode.** `videoMode` and `v_field_bounds` are copied into shadow registers under two conditions: during reset, and on the cycle the counters wrap from (h_total-1, v_total-1) to (0,0). All other logic uses only the shadow copy.
- **Counters.**
  - X counts 0..h_total-1, then returns to 0.
  - Y increments when X wraps and counts 0..v_total-1.
  - Reset sets both to 0.
  - If a shadowed total is 0 or 1, the counter holds at 0.
- **Blink.**
  - A frame counter counts 0..BLINK_FRAMES-1 and advances when X=0 and Y=0.
  - When it wraps, `show` toggles.
  - Reset clears the frame counter and `show`.
  - With BLINK_FRAMES=0, `show` is constant 1.
- **Syncs.**
  - hsync is at the active polarity while X < h_sync, otherwise inverted.
  - vsync is at the active polarity while Y < v_sync, otherwise inverted.
- **DE.** DE=1 when both hold:
  - hs+hbp ≤ X < hs+hbp+h_active
  - vs+vbp ≤ Y < vs+vbp+v_active
- **Pixel position.** xpos = X-(hs+hbp) and ypos = Y-(vs+vbp). All sums are computed in CNT_WIDTH+1 bits, so there is no wrap.
- **Pixel colour.**
  - White (FFFFFF) when all of the following hold: `show`=1, DE=1, h_field_start < xpos < h_field_end, and for any field i, start_i < ypos < end_i. All comparisons are strict.
  - Otherwise black, or colour bars when configured (see Configuration).
  - Pixel data is 0 whenever DE=0.
- Overlapping fields give plain white; they are not additive.

## Timing
- **Stage 0.** Counters, shadow mode and `show`.
- **Stage 1.** Registered de, hsync, vsync, data, frame_start and fields_visible, computed from the stage-0 state.
- **Delay.** Stage 1 is followed by OUT_DELAY register stages.
- **Latency.** Counter value to pins is 1+OUT_DELAY cycles; 3 at the defaults. All outputs share the same latency.
- **Reset.**
  - Every stage-1 and delay register clears to de=0 and data=0.
  - hsync/vsync go to the inactive level of `videoMode` as sampled during reset.
  - frame_start=0 and fields_visible=0.
- **First pixel after reset release.** The first frame_start appears OUT_DELAY+1 cycles after the first non-reset edge.
- **Reset mid-frame.** Takes effect on the next edge and flushes the pipeline. There are no partial-line artefacts after release.
- **Mode change mid-frame.** No effect until the wrap. The first pixel of the new mode is the one that produces frame_start.
- **Blink change.** A `show` toggle and its frame_start reach the outputs on the same cycle.

## Configuration
- Macro `VIDEO_PATTERN_COLORBAR_EN`.
- **Defined.**
  - Non-box active pixels show 8 vertical bars, in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bar width is h_active>>3, latched with the shadow mode.
  - A bar counter advances every bar-width pixels within each line and resets when DE falls.
  - The last bar absorbs the h_active remainder.
  - Box pixels override the bars with white only when `show`=1.
- **Undefined.** Non-box pixels are 0 and no bar logic is synthesised.

## Test plan
- **Small mode timing.** Mode h_total=20, hs=2, hbp=3, ha=10; v_total=12, vs=1, vbp=2, va=6; positive polarity; OUT_DELAY=2. Required: hsync high for 2 of every 20 cycles; de high for 10 consecutive cycles on 6 lines per frame; frame_start every 240 cycles, three cycles after counter (0,0).
- **Blink.** Same mode with one field: h_field 2..7, v 1..4, BLINK_FRAMES=2. Required: frames 0-1 all black; frames 2-3 white at xpos 3..6 and ypos 2..3; the pattern repeats with a period of 4 frames.
- **Mode change mid-frame.** Change ha to 8 at line 5. Required: current frame de still 10 wide; next frame, starting at frame_start, de 8 wide.
- **Reset mid-line.** Assert reset at X=7, Y=4 for 3 cycles. Required: de=0, data=0, syncs inactive during reset; after release, the first frame_start occurs 3 cycles later and the counters start from 0.
- **Totals.** Set h_total=1. Required: X is stuck at 0 and no hsync toggling. Set negative polarity. Required: hsync is low during sync.
- **Colour bars.** With `VIDEO_PATTERN_COLORBAR_EN` and ha=16, required output per line: 2 white pixels, 2 FFFF00, …, 2 000000, then de falls.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Video timing generator with blinking white field boxes, pipelined outputs.
// Optional colour bars behind the boxes when VIDEO_PATTERN_COLORBAR_EN is defined.
// videoMode packing, MSB first: h_sync, h_bp, h_active, h_total, v_sync, v_bp, v_active,
// v_total, h_field_start, h_field_end (CNT_WIDTH each), h_pol, v_pol (1 = active high).
module video_pattern_gen #(
   parameter int CNT_WIDTH    = 12,
   parameter int NUM_FIELDS   = 3,
   parameter int BLINK_FRAMES = 6,
   parameter int OUT_DELAY    = 2
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [10*CNT_WIDTH+1:0]           videoMode,
   input  logic [NUM_FIELDS*2*CNT_WIDTH-1:0] v_field_bounds,
   output logic [7:0]                        red,
   output logic [7:0]                        green,
   output logic [7:0]                        blue,
   output logic                              de,
   output logic                              hsync,
   output logic                              vsync,
   output logic                              frame_start,
   output logic                              fields_visible
);
   localparam int W1   = CNT_WIDTH + 1;
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef struct packed {
      logic [CNT_WIDTH-1:0] h_sync, h_bp, h_active, h_total;
      logic [CNT_WIDTH-1:0] v_sync, v_bp, v_active, v_total;
      logic [CNT_WIDTH-1:0] h_field_start, h_field_end;
      logic                 h_pol, v_pol;
   } mode_t;

   typedef struct packed {
      logic        de, hs, vs, fs, fv;
      logic [23:0] rgb;
   } pix_t;

   mode_t                             mode_in, mode_q;
   logic [NUM_FIELDS*2*CNT_WIDTH-1:0] bounds_q;
   logic [CNT_WIDTH-1:0]              x_q, x_d, y_q, y_d;
   logic [FC_W-1:0]                   fcnt_q, fcnt_d;
   logic                              show_q, show_d;
   logic                              x_wrap, y_wrap, f_wrap;

   assign mode_in = videoMode;

   // Stage 0: counters, blink phase and the shadow copy of the mode
   always_comb begin
      x_wrap = (mode_q.h_total <= CNT_WIDTH'(1)) || (x_q == mode_q.h_total - 1'b1);
      y_wrap = (mode_q.v_total <= CNT_WIDTH'(1)) || (y_q == mode_q.v_total - 1'b1);
      f_wrap = x_wrap && y_wrap;
      x_d    = x_wrap ? '0 : x_q + 1'b1;
      y_d    = y_q;
      if (x_wrap) y_d = y_wrap ? '0 : y_q + 1'b1;
      fcnt_d = fcnt_q;
      show_d = show_q;
      // Advancing on the wrap makes the new phase coincide with pixel (0,0)
      if (BLINK_FRAMES == 0) begin
         show_d = 1'b1;
      end else if (f_wrap) begin
         if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            fcnt_d = '0;
            show_d = ~show_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q      <= '0;
         y_q      <= '0;
         fcnt_q   <= '0;
         show_q   <= (BLINK_FRAMES == 0);
         mode_q   <= mode_in;
         bounds_q <= v_field_bounds;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         fcnt_q <= fcnt_d;
         show_q <= show_d;
         if (f_wrap) begin
            mode_q   <= mode_in;
            bounds_q <= v_field_bounds;
         end
      end
   end

   logic [W1-1:0] h_start, h_end, v_start, v_end, xpos, ypos;
   logic          de_p0, vhit_p0, box_p0;
   logic [23:0]   bar_rgb_p0;
   pix_t          pix_p0, rst_pix;

`ifdef VIDEO_PATTERN_COLORBAR_EN
   logic [CNT_WIDTH-1:0] bar_w_q, bar_pix_q;
   logic [2:0]           bar_idx_q;

   function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   endfunction

   always_ff @(posedge clock) begin
      if (reset || f_wrap) bar_w_q <= mode_in.h_active >> 3;
   end

   // The last bar never advances, so it absorbs the h_active remainder
   always_ff @(posedge clock) begin
      if (reset || !de_p0) begin
         bar_idx_q <= '0;
         bar_pix_q <= '0;
      end else if ((bar_w_q != '0) && (bar_pix_q == bar_w_q - 1'b1) && (bar_idx_q != 3'd7)) begin
         bar_idx_q <= bar_idx_q + 1'b1;
         bar_pix_q <= '0;
      end else begin
         bar_pix_q <= bar_pix_q + 1'b1;
      end
   end

   assign bar_rgb_p0 = bar_rgb(bar_idx_q);
`else
   assign bar_rgb_p0 = 24'h000000;
`endif

   always_comb begin
      h_start = {1'b0, mode_q.h_sync} + {1'b0, mode_q.h_bp};
      h_end   = h_start + {1'b0, mode_q.h_active};
      v_start = {1'b0, mode_q.v_sync} + {1'b0, mode_q.v_bp};
      v_end   = v_start + {1'b0, mode_q.v_active};
      xpos    = {1'b0, x_q} - h_start;
      ypos    = {1'b0, y_q} - v_start;
      de_p0   = ({1'b0, x_q} >= h_start) && ({1'b0, x_q} < h_end) &&
                ({1'b0, y_q} >= v_start) && ({1'b0, y_q} < v_end);
      vhit_p0 = 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (({1'b0, bounds_q[i*2*CNT_WIDTH +: CNT_WIDTH]} < ypos) &&
             (ypos < {1'b0, bounds_q[i*2*CNT_WIDTH+CNT_WIDTH +: CNT_WIDTH]}))
            vhit_p0 = 1'b1;
      end
      box_p0 = show_q && de_p0 && vhit_p0 &&
               ({1'b0, mode_q.h_field_start} < xpos) && (xpos < {1'b0, mode_q.h_field_end});

      pix_p0     = '0;
      pix_p0.de  = de_p0;
      pix_p0.hs  = (x_q < mode_q.h_sync) ? mode_q.h_pol : ~mode_q.h_pol;
      pix_p0.vs  = (y_q < mode_q.v_sync) ? mode_q.v_pol : ~mode_q.v_pol;
      pix_p0.fs  = (x_q == '0) && (y_q == '0);
      pix_p0.fv  = show_q;
      if (box_p0)     pix_p0.rgb = 24'hFFFFFF;
      else if (de_p0) pix_p0.rgb = bar_rgb_p0;

      rst_pix    = '0;
      rst_pix.hs = ~mode_in.h_pol;
      rst_pix.vs = ~mode_in.v_pol;
   end

   // Stage 1 is pipe_q[0]; the remaining entries are the output delay stages
   pix_t pipe_q [0:OUT_DELAY];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i <= OUT_DELAY; i++) pipe_q[i] <= rst_pix;
      end else begin
         pipe_q[0] <= pix_p0;
         for (int i = 1; i <= OUT_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign de                 = pipe_q[OUT_DELAY].de;
   assign hsync              = pipe_q[OUT_DELAY].hs;
   assign vsync              = pipe_q[OUT_DELAY].vs;
   assign frame_start        = pipe_q[OUT_DELAY].fs;
   assign fields_visible     = pipe_q[OUT_DELAY].fv;
   assign {red, green, blue} = pipe_q[OUT_DELAY].rgb;

endmodule
